// File: rtl/pkg_param_streamer_if.sv
// Request/beat bus of pkg_param_streamer: index request in, fixed-width beats out.
// slave = the streamer, master = the requester/sink.
interface pkg_param_streamer_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [IDX_W-1:0]  req_idx;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [9:0]        out_width;
  logic              err;

  modport slave (
    input  req_valid, req_idx, out_ready,
    output req_ready, out_valid, out_data, out_last, out_width, err
  );

  modport master (
    output req_valid, req_idx, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_width, err
  );
endinterface

// File: rtl/pkg_param_streamer.sv
// Streams one package constant (chosen by index) as LSB-first zero-extended beats.
// Optional PKG_STREAM_CHECKSUM_EN appends an XOR-of-all-data-beats beat that carries out_last.
module pkg_param_streamer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  pkg_param_streamer_if.slave bus
);
  localparam int TBL_W   = 640;
  localparam int NUM_ENT = 15;
  localparam int CTR_W   = $clog2(600 / DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_ERR} state_t;

  function automatic logic [9:0] width_of(input logic [IDX_W-1:0] idx);
    case (int'(idx))
      2:       return 10'd1;
      3:       return 10'd2;
      4:       return 10'd600;
      5, 11:   return 10'd8;
      6:       return 10'd16;
      8, 12:   return 10'd64;
      10:      return 10'd130;
      default: return 10'd32;
    endcase
  endfunction

  function automatic logic [TBL_W-1:0] val_of(input logic [IDX_W-1:0] idx);
    logic [TBL_W-1:0] v;
    v = '0;
    case (int'(idx))
      0:  v[31:0] = 32'd5;
      1:  v[31:0] = 32'd8;
      2:  v[0]    = 1'b1;
      3:  v[1:0]  = 2'd3;
      4:  v[83:0] = 84'ha364c9849f8298c66d659;
      5:  v[7:0]  = 8'd100;
      6:  v[15:0] = 16'hF618;
      7:  v[31:0] = 32'd50;
      8:  v[43:0] = 44'h11c98c031cb;
      9:  v[31:0] = 32'd125000;
      10: v[63:0] = 64'h8c523ec7dc553a2b;
      11: v[7:0]  = 8'd200;
      12: v[35:0] = 36'h2540be400;
      13: v[31:0] = 32'd11;
      14: v[31:0] = 32'd4;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [CTR_W-1:0] nbeats_of(input logic [IDX_W-1:0] idx);
    int n;
    n = (int'(width_of(idx)) + DATA_W - 1) / DATA_W;
    return CTR_W'(n);
  endfunction

  // Bits at or above the declared width always read as zero.
  function automatic logic [DATA_W-1:0] beat_of(input logic [IDX_W-1:0] idx,
                                                input logic [CTR_W-1:0] ctr);
    logic [TBL_W-1:0] v;
    v = val_of(idx) & ~({TBL_W{1'b1}} << width_of(idx));
    v = v >> (int'(ctr) * DATA_W);
    return v[DATA_W-1:0];
  endfunction

  state_t            r_state;
  logic              r_req_ready;
  logic              r_out_valid;
  logic              r_last;
  logic [DATA_W-1:0] r_data;
  logic [9:0]        r_width;
  logic              r_err;
  logic [CTR_W-1:0]  r_ctr;
  logic [CTR_W-1:0]  r_n;
  logic [IDX_W-1:0]  r_idx;
  logic [CTR_W-1:0]  w_ctr_nxt;
`ifdef PKG_STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  assign w_ctr_nxt = r_ctr + CTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= '0;
      r_width     <= '0;
      r_err       <= 1'b0;
      r_ctr       <= '0;
      r_n         <= '0;
      r_idx       <= '0;
`ifdef PKG_STREAM_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_req_ready <= 1'b0;
          if (int'(bus.req_idx) < NUM_ENT) begin
            r_idx   <= bus.req_idx;
            r_state <= S_LOAD;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_LOAD: begin
          r_width     <= width_of(r_idx);
          r_n         <= nbeats_of(r_idx);
          r_ctr       <= '0;
          r_data      <= beat_of(r_idx, '0);
          r_out_valid <= 1'b1;
`ifdef PKG_STREAM_CHECKSUM_EN
          r_last      <= 1'b0;
          r_csum      <= '0;
`else
          r_last      <= (nbeats_of(r_idx) == CTR_W'(1));
`endif
          r_state     <= S_STREAM;
        end
        S_STREAM: if (bus.out_ready) begin
          if (r_last) begin
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_ctr <= w_ctr_nxt;
`ifdef PKG_STREAM_CHECKSUM_EN
            // Counter slot N is the checksum beat that follows the N data beats.
            r_csum <= r_csum ^ r_data;
            if (w_ctr_nxt == r_n) begin
              r_data <= r_csum ^ r_data;
              r_last <= 1'b1;
            end else begin
              r_data <= beat_of(r_idx, w_ctr_nxt);
              r_last <= 1'b0;
            end
`else
            r_data <= beat_of(r_idx, w_ctr_nxt);
            r_last <= (w_ctr_nxt == r_n - CTR_W'(1));
`endif
          end
        end
        S_ERR: begin
          r_err       <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign bus.out_width = r_width;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_pkg_param_streamer.sv
// Directed + randomized bench for pkg_param_streamer (DATA_W=32) against a table-driven beat model.
module tb_pkg_param_streamer;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkg_param_streamer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus();
  pkg_param_streamer #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  int exp_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: constant table as plain numbers, cut into 32-bit slices.
  task automatic build_exp(input int idx);
    logic [639:0] v;
    int n;
    logic [DATA_W-1:0] x;
    v = '0;
    case (idx)
      0: begin exp_w = 32;  v = 640'd5; end
      1: begin exp_w = 32;  v = 640'd8; end
      2: begin exp_w = 1;   v = 640'd1; end
      3: begin exp_w = 2;   v = 640'd3; end
      4: begin exp_w = 600; v = 640'ha364c9849f8298c66d659; end
      5: begin exp_w = 8;   v = 640'd100; end
      6: begin exp_w = 16;  v = 640'hF618; end
      7: begin exp_w = 32;  v = 640'd50; end
      8: begin exp_w = 64;  v = 640'h11c98c031cb; end
      9: begin exp_w = 32;  v = 640'd125000; end
      10: begin exp_w = 130; v = 640'h8c523ec7dc553a2b; end
      11: begin exp_w = 8;   v = 640'd200; end
      12: begin exp_w = 64;  v = 640'h2540be400; end
      13: begin exp_w = 32;  v = 640'd11; end
      default: begin exp_w = 32; v = 640'd4; end
    endcase
    for (int b = exp_w; b < 640; b++) v[b] = 1'b0;
    n = (exp_w + DATA_W - 1) / DATA_W;
    exp_q.delete();
    x = '0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(v[k*DATA_W +: DATA_W]);
      x ^= v[k*DATA_W +: DATA_W];
    end
`ifdef PKG_STREAM_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after the stream.
  // mode 0: always ready, 1: ready toggles 1/0, 2: random ready + req_valid noise.
  task automatic run_req(input int idx, input int mode);
    int k, n, cyc;
    logic rdy, tog;
    build_exp(idx);
    n = exp_q.size();
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_idx   = IDX_W'(idx);
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    chk("load_no_valid", bus.out_valid, 0);
    chk("load_req_ready", bus.req_ready, 0);
    @(posedge clk); @(negedge clk);
    k = 0; cyc = 0; tog = 1'b1;
    while (k < n && cyc < 400) begin
      chk("beat_valid", bus.out_valid, 1);
      chk($sformatf("beat%0d_data", k), bus.out_data, exp_q[k]);
      chk($sformatf("beat%0d_last", k), bus.out_last, (k == n - 1));
      chk("beat_width", bus.out_width, exp_w);
      chk("stream_req_ready", bus.req_ready, 0);
      case (mode)
        0: rdy = 1'b1;
        1: begin rdy = tog; tog = ~tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (mode == 2 && !(rdy && k == n - 1)) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_idx   = IDX_W'($urandom_range(0, 15));
      end else bus.req_valid = 1'b0;
      @(posedge clk);
      if (rdy) k++;
      @(negedge clk);
      cyc++;
    end
    if (k < n) chk("stream_timeout", k, n);
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("post_valid_low", bus.out_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
  endtask

  task automatic run_err(input int idx);
    chk("err_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_idx   = IDX_W'(idx);
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    chk("err_pulse", bus.err, 1);
    chk("err_no_valid", bus.out_valid, 0);
    chk("err_req_ready_low", bus.req_ready, 0);
    @(posedge clk); @(negedge clk);
    chk("err_cleared", bus.err, 0);
    chk("err_no_valid2", bus.out_valid, 0);
    chk("err_req_ready_back", bus.req_ready, 1);
  endtask

  initial begin
    int idx;
    bus.req_valid = 1'b0;
    bus.req_idx   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_width", bus.out_width, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    run_req(6, 0);
    run_req(4, 0);
    run_req(8, 1);
    run_err(15);

    // Reset in the middle of idx 12, then a clean idx 2.
    build_exp(12);
    bus.req_valid = 1'b1;
    bus.req_idx   = 4'd12;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_beat0", bus.out_data, exp_q[0]);
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_beat1", bus.out_data, exp_q[1]);
    chk("rst_mid_valid", bus.out_valid, 1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid_low", bus.out_valid, 0);
    chk("rst_mid_last_low", bus.out_last, 0);
    chk("rst_mid_req_ready", bus.req_ready, 1);
    run_req(2, 0);

    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 15);
      if (idx >= 15) run_err(idx);
      else run_req(idx, $urandom_range(0, 2));
    end
    run_req(0, 2);
    run_req(14, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
